mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory between the core's instruction-fetch requester (port 0) and its load/store requester (port 1).
- Sequences each access: arbitration, a one-cycle memory issue, a wait of the fixed read latency, then a one-cycle completion pulse with registered read data.
- Sits between the core state machine and the memory array. The core's FETCH_INSTR and LOAD/STORE states each wait on their port's done pulse.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch port (0)
// and the load/store port (1); each access is IDLE -> ISSUE -> [WAIT] -> RESP.
module mem_port_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic [31:0]       rdata0,
    output logic              done0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        wmask1,
    output logic [31:0]       rdata1,
    output logic              done1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wmask_q;
    logic              mem_rstrb_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;
    logic              done0_q;
    logic              done1_q;

    logic              grant_d;
    logic              owner_d;

    // On a conflict the port that did not win last time gets the memory.
    always_comb begin
        grant_d = req0 | req1;
        owner_d = 1'b0;
        if (req0 && req1) begin
            owner_d = ~last_owner_q;
        end else if (req1) begin
            owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            mem_rstrb_q  <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q      <= owner_d;
                        last_owner_q <= owner_d;
                        mem_addr_q   <= owner_d ? addr1 : addr0;
                        mem_wdata_q  <= owner_d ? wdata1 : 32'h0;
                        mem_wmask_q  <= owner_d ? wmask1 : 4'h0;
                        mem_rstrb_q  <= ~owner_d | (wmask1 == 4'h0);
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rstrb_q <= 1'b0;
                    mem_wmask_q <= '0;
                    if (mem_rstrb_q) begin
                        cnt_q   <= LAT_M1;
                        state_q <= WAIT;
                    end else begin
                        done1_q <= owner_q;
                        done0_q <= ~owner_q;
                        state_q <= RESP;
                    end
                end
                WAIT: begin
                    // mem_rdata is only trusted on the final counted cycle.
                    if (cnt_q == 4'h0) begin
                        if (owner_q) begin
                            rdata1_q <= mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                        done1_q <= owner_q;
                        done0_q <= ~owner_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'h1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_rstrb = mem_rstrb_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected transactions,
// a negedge monitor checks issue, arbitration order, latency and read data.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 30;
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              req0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [31:0]       rdata0;
    logic              done0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [31:0]       wdata1 = '0;
    logic [3:0]        wmask1 = '0;
    logic [31:0]       rdata1;
    logic              done1;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic [31:0]       mem_rdata = '0;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .addr0(addr0), .rdata0(rdata0), .done0(done0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .wmask1(wmask1),
        .rdata1(rdata1), .done1(done1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                isWrite;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wmask;
        logic [31:0]       rdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] memArr[128];
    logic [31:0] refArr[128];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] initWord(int i);
        return 32'h3C000000 + 32'(i) * 32'h00010203;
    endfunction

    function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] wd, logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // Transaction-level expectation; the reference memory is updated in request order.
    function automatic txn_t makeTxn(int port, logic [ADDR_W-1:0] a, logic [31:0] wd, logic [3:0] wm);
        txn_t t;
        t.addr    = a;
        t.wmask   = (port == 0) ? 4'h0 : wm;
        t.wdata   = wd;
        t.isWrite = (t.wmask != 4'h0);
        t.rdata   = refArr[a[6:0]];
        if (t.isWrite) refArr[a[6:0]] = mergeBytes(refArr[a[6:0]], wd, t.wmask);
        return t;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory with fixed read latency; data is valid only in the cycle LAT after the strobe.
    int                pendCnt = 0;
    logic [ADDR_W-1:0] pendAddr = '0;
    always @(posedge clk) begin
        if (pendCnt > 0) pendCnt--;
        if (resetn && mem_rstrb) begin
            pendAddr = mem_addr;
            pendCnt  = LAT;
        end
        if (resetn && mem_wmask != 4'h0)
            memArr[mem_addr[6:0]] = mergeBytes(memArr[mem_addr[6:0]], mem_wdata, mem_wmask);
        #1;
        mem_rdata = (pendCnt == 1) ? memArr[pendAddr[6:0]] : $urandom;
    end

    int          cyc = 0;
    int          grantCyc = 0;
    bit          prevBusy = 0;
    bit          lastR0 = 0;
    bit          lastR1 = 0;
    bit          lastOwner = 1;
    bit          inFlight = 0;
    bit          curOwner = 0;
    bit          curWrite = 0;
    logic [31:0] mRd0 = '0;
    logic [31:0] mRd1 = '0;

    // Monitor: judges each issue and completion against the round-robin rules.
    always @(negedge clk) begin
        txn_t t;
        bit   w;
        cyc++;
        if (!resetn) begin
            q0.delete();
            q1.delete();
            lastOwner = 1;
            inFlight  = 0;
            prevBusy  = 0;
            lastR0    = 0;
            lastR1    = 0;
            mRd0      = '0;
            mRd1      = '0;
        end else begin
            if (done0 && done1) checkOutput("done exclusive", {done0, done1}, 32'h1);
            if (busy && !prevBusy) begin
                w = (lastR0 && lastR1) ? ~lastOwner : lastR1;
                if (!lastR0 && !lastR1) begin
                    checkOutput("spurious grant", 32'h1, 32'h0);
                end else if ((w ? q1.size() : q0.size()) == 0) begin
                    checkOutput("grant queue empty", 32'(w), 32'(~w));
                end else begin
                    t = w ? q1[0] : q0[0];
                    checkOutput("issue addr", 32'(mem_addr), 32'(t.addr));
                    checkOutput("issue wmask", 32'(mem_wmask), 32'(t.wmask));
                    checkOutput("issue rstrb", 32'(mem_rstrb), 32'(!t.isWrite));
                    if (t.isWrite) checkOutput("issue wdata", mem_wdata, t.wdata);
                    lastOwner = w;
                    inFlight  = 1;
                    curOwner  = w;
                    curWrite  = t.isWrite;
                    grantCyc  = cyc - 1;
                end
            end else if (mem_rstrb || mem_wmask != 4'h0) begin
                checkOutput("strobe outside issue", {mem_rstrb, mem_wmask}, 32'h0);
            end
            if (done0 || done1) begin
                if (!inFlight) begin
                    checkOutput("unexpected done", {done0, done1}, 32'h0);
                end else begin
                    checkOutput("done port", 32'(done1), 32'(curOwner));
                    checkOutput("latency", 32'(cyc - grantCyc), curWrite ? 32'd2 : 32'(2 + LAT));
                    if (curOwner) begin
                        if (q1.size() > 0) t = q1.pop_front();
                        if (!curWrite) mRd1 = t.rdata;
                    end else begin
                        if (q0.size() > 0) t = q0.pop_front();
                        if (!curWrite) mRd0 = t.rdata;
                    end
                    checkOutput("rdata0", rdata0, mRd0);
                    checkOutput("rdata1", rdata1, mRd1);
                    inFlight = 0;
                end
            end
            if (!busy) begin
                lastR0 = req0;
                lastR1 = req1;
            end
            prevBusy = busy;
        end
    end

    // Issue one request, hold it until its done, drop it on the done edge.
    task automatic applyStimulus(int port, logic [ADDR_W-1:0] a, logic [31:0] wd, logic [3:0] wm);
        bit got;
        if (port == 0) begin
            q0.push_back(makeTxn(0, a, wd, wm));
            addr0 = a;
            req0  = 1'b1;
        end else begin
            q1.push_back(makeTxn(1, a, wd, wm));
            addr1  = a;
            wdata1 = wd;
            wmask1 = wm;
            req1   = 1'b1;
        end
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ((port == 0) ? done0 : done1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checkOutput($sformatf("done%0d timeout", port), 32'h0, 32'h1);
            if (port == 0) q0.delete(); else q1.delete();
        end
        @(posedge clk);
        #1;
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic idleCycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] oldWord;
        int          doneSeen;
        for (int i = 0; i < 128; i++) begin
            memArr[i] = initWord(i);
            refArr[i] = initWord(i);
        end
        memArr[5] = 32'hDEADBEEF;
        refArr[5] = 32'hDEADBEEF;

        idleCycles(3);
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", {done0, done1}, 32'h0);
        checkOutput("reset rdata0", rdata0, 32'h0);
        checkOutput("reset rdata1", rdata1, 32'h0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset mem_strobes", {mem_rstrb, mem_wmask}, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idleCycles(2);

        applyStimulus(0, 30'd5, 32'h0, 4'h0);
        checkOutput("fetch data", rdata0, 32'hDEADBEEF);
        idleCycles(1);

        oldWord = memArr[3];
        applyStimulus(1, 30'd3, 32'h12345678, 4'b0011);
        checkOutput("store merge", memArr[3], {oldWord[31:16], 16'h5678});
        checkOutput("store rdata1", rdata1, 32'h0);
        idleCycles(1);

        fork
            applyStimulus(0, 30'd9, 32'h0, 4'h0);
            begin
                @(posedge clk);
                #2;
                addr0 = 30'd20;
            end
        join
        checkOutput("stable fetch data", rdata0, initWord(9));

        fork
            for (int n = 0; n < 40; n++) begin
                idleCycles($urandom_range(0, 3));
                applyStimulus(0, 30'($urandom_range(0, 63)), 32'h0, 4'h0);
            end
            for (int n = 0; n < 40; n++) begin
                idleCycles($urandom_range(0, 3));
                applyStimulus(1, 30'($urandom_range(64, 127)), $urandom,
                              ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)));
            end
        join

        fork
            repeat (12) applyStimulus(0, 30'($urandom_range(0, 63)), 32'h0, 4'h0);
            repeat (12) applyStimulus(1, 30'($urandom_range(64, 127)), 32'h0, 4'h0);
        join
        idleCycles(2);

        // Abort a load in the middle of its wait; nothing may complete afterwards.
        q1.push_back(makeTxn(1, 30'd70, 32'h0, 4'h0));
        addr1  = 30'd70;
        wmask1 = 4'h0;
        req1   = 1'b1;
        idleCycles(3);
        resetn = 1'b0;
        req1   = 1'b0;
        idleCycles(1);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort rdata", rdata0 | rdata1, 32'h0);
        doneSeen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done0 || done1) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(0, 30'd11, 32'h0, 4'h0);
        checkOutput("post-abort fetch", rdata0, initWord(11));

        idleCycles(4);
        @(negedge clk);
        checkOutput("final idle", 32'(busy), 32'h0);
        checkOutput("final queues", 32'(q0.size() + q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
